// File: rtl/risc_v_lsu_if.sv
// Request/response handshake and word-memory port of the load/store unit.
// master = datapath and memory side, slave = the LSU itself.
interface risc_v_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [2:0]              req_funct3;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_write;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_write, mem_wdata
    );
endinterface

// File: rtl/risc_v_lsu.sv
// RISC-V load/store unit in front of a word-only memory: alignment checks,
// load extension, and read-modify-write for byte/half stores.
module risc_v_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    risc_v_lsu_if.slave   bus
);
    localparam int BAW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic                    write_q;
    logic [2:0]              funct3_q;
    logic [BAW-1:0]          addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    resp_err_q;
    logic                    accept_s;
    logic                    legal_s;
    logic                    is_sw_s;

    function automatic logic req_legal(input logic write, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok_f3;
        logic ok_al;
        case (f3)
            3'b000: begin ok_f3 = 1'b1;   ok_al = 1'b1;           end
            3'b001: begin ok_f3 = 1'b1;   ok_al = ~off[0];        end
            3'b010: begin ok_f3 = 1'b1;   ok_al = (off == 2'b00); end
            3'b100: begin ok_f3 = ~write; ok_al = 1'b1;           end
            3'b101: begin ok_f3 = ~write; ok_al = ~off[0];        end
            default: begin ok_f3 = 1'b0;  ok_al = 1'b0;           end
        endcase
        return ok_f3 & ok_al;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (f3)
            3'b000: r[{off, 3'b000} +: 8] = wdata[7:0];
            3'b001: begin
                if (off[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign accept_s = (state_q == ST_IDLE) & bus.req_valid;
    assign legal_s  = req_legal(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);
    assign is_sw_s  = bus.req_write & (bus.req_funct3 == 3'b010);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; SW skips the read, sub-word stores read first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!legal_s) begin
                        state_d = ST_RESP;
                    end else if (is_sw_s) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD:   state_d = write_q ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, memory write data and held response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_q  <= bus.req_write;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        if (!legal_s) begin
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end else if (is_sw_s) begin
                            mem_wdata_q  <= bus.req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (write_q) begin
                        mem_wdata_q <= store_merge(bus.mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
                    end else begin
                        resp_rdata_q <= load_extract(bus.mem_rdata, funct3_q, addr_q[1:0]);
                        resp_err_q   <= 1'b0;
                    end
                end
                ST_WR: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    resp_err_q <= resp_err_q;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.mem_write  = (state_q == ST_WR);
        bus.resp_valid = (state_q == ST_RESP);
        bus.mem_addr   = addr_q[BAW-1:2];
        bus.mem_wdata  = mem_wdata_q;
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;
    end
endmodule

// File: tb/tb_risc_v_lsu.sv
// Bench for risc_v_lsu: directed scenarios plus randomized traffic checked
// against a byte-array memory model.
module tb_risc_v_lsu;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc_v_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus();
    risc_v_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:31];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;
    logic [7:0]  ref_b [0:127];
    int n_checks = 0;
    int n_fail = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[int'(a) * 4 + i] = d[8*i +: 8];
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_legal(input logic w, input logic [2:0] f3, input int addr);
        int n;
        case (f3)
            3'd0: n = 1;
            3'd1: n = 2;
            3'd2: n = 4;
            3'd4: n = w ? 0 : 1;
            3'd5: n = w ? 0 : 2;
            default: n = 0;
        endcase
        if (n == 0) return 1'b0;
        return (addr % n) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int addr);
        longint v = 0;
        int n = nbytes(f3);
        for (int i = 0; i < n; i++) v += longint'(ref_b[addr + i]) << (8 * i);
        if (!f3[2] && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input int addr, input logic [31:0] d);
        for (int i = 0; i < nbytes(f3); i++) ref_b[addr + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_word(input int wa);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_b[wa * 4 + i];
        return r;
    endfunction

    // Issue one request and observe it until its response (bounded).
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [6:0] a,
                           input logic [31:0] d, output int lat, output logic [31:0] rd,
                           output logic er, output int nwr, output int wr_cyc,
                           output logic [31:0] wr_data, output logic [4:0] wr_addr,
                           output logic [4:0] resp_addr);
        lat = -1; rd = '0; er = 1'b0; nwr = 0; wr_cyc = -1;
        wr_data = '0; wr_addr = '0; resp_addr = '0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_write) begin
                nwr++; wr_cyc = c; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                lat = c; rd = bus.resp_rdata; er = bus.resp_err; resp_addr = bus.mem_addr;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_checks++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_write} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.resp_valid, bus.resp_err, bus.mem_write});
        end
        n_checks++;
        if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
        n_checks++;
        if (bus.mem_addr !== 5'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", bus.mem_addr); end
        n_checks++;
        if (bus.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) preload(i[4:0], 32'd0);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [6:0]  ads [6] = '{7'h0C, 7'h0F, 7'h0F, 7'h0E, 7'h0C, 7'h0C};
        logic [31:0] exp [6] = '{32'h823456F0, 32'hFFFFFF82, 32'h00000082,
                                 32'hFFFF8234, 32'h000056F0, 32'hFFFFFFF0};
        int lat, nwr, wc; logic [31:0] rd, wd; logic er; logic [4:0] wa, ra;
        for (int i = 0; i < 6; i++) begin
            preload(5'd3, 32'h823456F0);
            run_req(1'b0, f3s[i], ads[i], $urandom, lat, rd, er, nwr, wc, wd, wa, ra);
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
            n_checks++;
            if (rd !== exp[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exp[i]); end
            n_checks++;
            if (er !== 1'b0 || nwr !== 0) begin
                n_fail++; $display("FAIL load%0d_err_write: got err=%b writes=%0d want 0/0", i, er, nwr);
            end
        end
    endtask

    task automatic test_sub_store();
        int lat, nwr, wc; logic [31:0] rd, wd; logic er; logic [4:0] wa, ra;
        preload(5'd3, 32'h823456F0);
        run_req(1'b1, 3'b000, 7'h0D, 32'h000000AB, lat, rd, er, nwr, wc, wd, wa, ra);
        model_store(3'b000, 13, 32'h000000AB);
        n_checks++;
        if (nwr !== 1 || wc !== 2) begin n_fail++; $display("FAIL sb_write_cycle: got n=%0d cyc=%0d want 1/2", nwr, wc); end
        n_checks++;
        if (wd !== 32'h8234ABF0) begin n_fail++; $display("FAIL sb_wdata: got %h want 8234abf0", wd); end
        n_checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
            n_fail++; $display("FAIL sb_resp: got lat=%0d err=%b rdata=%h want 3/0/0", lat, er, rd);
        end
        run_req(1'b0, 3'b010, 7'h0C, 32'd0, lat, rd, er, nwr, wc, wd, wa, ra);
        n_checks++;
        if (rd !== 32'h8234ABF0) begin n_fail++; $display("FAIL sb_readback: got %h want 8234abf0", rd); end
    endtask

    task automatic test_errors();
        logic       ws  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0] f3s [4] = '{3'b010, 3'b001, 3'b100, 3'b011};
        logic [6:0] ads [4] = '{7'h0D, 7'h0F, 7'h0C, 7'h0C};
        int lat, nwr, wc; logic [31:0] rd, wd; logic er; logic [4:0] wa, ra;
        for (int i = 0; i < 4; i++) begin
            preload(5'd3, 32'h823456F0);
            run_req(1'b0, 3'b010, 7'h0C, 32'd0, lat, rd, er, nwr, wc, wd, wa, ra);
            run_req(ws[i], f3s[i], ads[i], 32'h5A5A5A5A, lat, rd, er, nwr, wc, wd, wa, ra);
            n_checks++;
            if (lat !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL err%0d_resp: got lat=%0d err=%b want 1/1", i, lat, er); end
            n_checks++;
            if (rd !== 32'd0 || nwr !== 0) begin n_fail++; $display("FAIL err%0d_side: got rdata=%h writes=%0d want 0/0", i, rd, nwr); end
        end
        n_checks++;
        if (mem[3] !== 32'h823456F0) begin n_fail++; $display("FAIL err_mem_intact: got %h want 823456f0", mem[3]); end
    endtask

    task automatic test_back_to_back();
        int nresp = 0; logic [31:0] lw_rd = '0; int lw_cyc = -1;
        preload(5'd3, 32'h823456F0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 7'h0D; bus.req_wdata = 32'h000000AB;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin nresp++; if (c > 3) begin lw_rd = bus.resp_rdata; lw_cyc = c; end end
            if (c == 4 || c == 7) begin
                n_checks++;
                if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b want 1", c, bus.req_ready); end
            end
            if (c == 5 || c == 6) begin
                n_checks++;
                if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_c%0d: got %b want 0", c, bus.req_ready); end
            end
            if (c == 1) begin
                bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'b010;
                bus.req_addr = 7'h0C; bus.req_wdata = 32'd0;
            end
            if (c == 6) bus.req_valid = 1'b0;
        end
        model_store(3'b000, 13, 32'h000000AB);
        n_checks++;
        if (nresp !== 2 || lw_cyc !== 6) begin n_fail++; $display("FAIL b2b_count: got resp=%0d lw_cyc=%0d want 2/6", nresp, lw_cyc); end
        n_checks++;
        if (lw_rd !== model_word(3)) begin n_fail++; $display("FAIL b2b_rdata: got %h want %h", lw_rd, model_word(3)); end
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        preload(5'd3, 32'h823456F0);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 7'h0D; bus.req_wdata = 32'h00000011;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got ready=%b resp=%b want 1/0", bus.req_ready, bus.resp_valid);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.resp_valid || bus.mem_write) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
        n_checks++;
        if (mem[3] !== 32'h823456F0) begin n_fail++; $display("FAIL abort_mem: got %h want 823456f0", mem[3]); end
    endtask

    task automatic test_wrap();
        int lat, nwr, wc; logic [31:0] rd, wd; logic er; logic [4:0] wa, ra;
        run_req(1'b1, 3'b010, 7'h7C, 32'hDEADBEEF, lat, rd, er, nwr, wc, wd, wa, ra);
        model_store(3'b010, 124, 32'hDEADBEEF);
        n_checks++;
        if (lat !== 2 || nwr !== 1 || wc !== 1) begin
            n_fail++; $display("FAIL sw_timing: got lat=%0d n=%0d cyc=%0d want 2/1/1", lat, nwr, wc);
        end
        n_checks++;
        if (wa !== 5'd31 || wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_data: got %0d/%h want 31/deadbeef", wa, wd); end
        run_req(1'b0, 3'b010, 7'h7C, 32'd0, lat, rd, er, nwr, wc, wd, wa, ra);
        n_checks++;
        if (rd !== 32'hDEADBEEF || ra !== 5'd31) begin n_fail++; $display("FAIL wrap_load: got %h@%0d want deadbeef@31", rd, ra); end
    endtask

    task automatic test_random();
        int lat, nwr, wc, exp_lat; logic [31:0] rd, wd, d, exp_rd; logic er, w, legal;
        logic [4:0] wa, ra; logic [2:0] f3; logic [6:0] a;
        for (int it = 0; it < 300; it++) begin
            w = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
            a = 7'($urandom_range(0, 127)); d = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
            end
            legal = model_legal(w, f3, int'(a));
            exp_lat = !legal ? 1 : (!w || f3 == 3'b010) ? 2 : 3;
            exp_rd = (legal && !w) ? model_load(f3, int'(a)) : 32'd0;
            if (legal && w) model_store(f3, int'(a), d);
            run_req(w, f3, a, d, lat, rd, er, nwr, wc, wd, wa, ra);
            n_checks++;
            if (lat !== exp_lat || er !== !legal) begin
                n_fail++; $display("FAIL rnd%0d_resp: got lat=%0d err=%b want %0d/%b", it, lat, er, exp_lat, !legal);
            end
            n_checks++;
            if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", it, rd, exp_rd); end
            n_checks++;
            if (nwr !== ((legal && w) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_nwrites: got %0d", it, nwr); end
            if (legal && w) begin
                n_checks++;
                if (wd !== model_word(int'(a[6:2])) || wa !== a[6:2]) begin
                    n_fail++; $display("FAIL rnd%0d_wdata: got %h@%0d want %h@%0d", it, wd, wa, model_word(int'(a[6:2])), a[6:2]);
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (mem[i] !== model_word(i)) begin n_fail++; $display("FAIL rnd_mem%0d: got %h want %h", i, mem[i], model_word(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sub_store();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
